// File: rtl/mult_mode_sequencer.sv
// mult_mode_sequencer
//
// Sequences one job of operand pairs through an external split-precision
// multiplier and sums the lane products of every pair into an accumulator.
// The multiplier registers its product, so a pair accepted at edge t is
// accumulated at edge t+2. A 2-bit valid shift pipeline tracks the pairs
// that are still in flight.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   cfg_start/mode/len     job start strobe, precision mode, pair count
//   cfg_a_sign/b_sign      signed-operand flags
//   busy, err_mode         not-idle flag; one-cycle pulse on an illegal-mode start
//   in_valid/ready/a/b     operand stream
//   mul_A/B, mul_*_sign    registered operand and sign drive to the multiplier
//   mul_HALF_0/1/2         lane-split selects
//   mul_C                  multiplier product (1-cycle registered latency)
//   res_valid/ready/data   result handshake
//
// state | meaning
// IDLE  | waiting for cfg_start
// RUN   | accepting operand pairs
// DRAIN | all pairs accepted, waiting for in-flight products
// DONE  | result presented until res_ready
module mult_mode_sequencer #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [1:0]       cfg_mode,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_a_sign,
    input  logic             cfg_b_sign,
    output logic             busy,
    output logic             err_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_A,
    output logic [7:0]       mul_B,
    output logic             mul_A_sign,
    output logic             mul_B_sign,
    output logic             mul_HALF_0,
    output logic             mul_HALF_1,
    output logic             mul_HALF_2,
    input  logic [15:0]      mul_C,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q;
    logic               a_sign_q, b_sign_q;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic [1:0]         vld_q;
    logic [ACC_W-1:0]   acc_q, lane_sum;
    logic               err_q;
    logic               accept, last_pair, start_ok, start_bad, finish, sx;

    function automatic logic [ACC_W-1:0] ext16(input logic [15:0] x, input logic s);
        return {{(ACC_W-16){s & x[15]}}, x};
    endfunction

    function automatic logic [ACC_W-1:0] ext8(input logic [7:0] x, input logic s);
        return {{(ACC_W-8){s & x[7]}}, x};
    endfunction

    function automatic logic [ACC_W-1:0] ext4(input logic [3:0] x, input logic s);
        return {{(ACC_W-4){s & x[3]}}, x};
    endfunction

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign res_valid  = (state_q == DONE);
    assign res_data   = acc_q;
    assign err_mode   = err_q;
    assign mul_A_sign = a_sign_q;
    assign mul_B_sign = b_sign_q;
    assign mul_HALF_0 = 1'b0;
    // mode_q is latched on the start edge and cleared on return to IDLE,
    // so the lane selects stay constant for the whole job.
    assign mul_HALF_1 = (mode_q == 2'd1);
    assign mul_HALF_2 = (mode_q == 2'd2);

    assign accept    = in_valid && in_ready;
    assign last_pair = accept && (cnt_q == len_q - 1'b1);
    assign start_ok  = (state_q == IDLE) && cfg_start && (cfg_mode != 2'd3);
    assign start_bad = (state_q == IDLE) && cfg_start && (cfg_mode == 2'd3);
    assign finish    = (state_q == DONE) && res_ready;
    // Any signed operand makes every lane product a signed quantity.
    assign sx        = a_sign_q || b_sign_q;

    always_comb begin
        lane_sum = '0;
        case (mode_q)
            2'd0:    lane_sum = ext16(mul_C, sx);
            2'd1:    lane_sum = ext8(mul_C[7:0], sx) + ext8(mul_C[15:8], sx);
            2'd2:    lane_sum = ext4(mul_C[3:0], sx) + ext4(mul_C[7:4], sx)
                              + ext4(mul_C[11:8], sx) + ext4(mul_C[15:12], sx);
            default: lane_sum = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = (cfg_len == '0) ? DONE : RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (vld_q == 2'b00) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            len_q    <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            mul_A    <= '0;
            mul_B    <= '0;
        end else begin
            err_q <= start_bad;
            vld_q <= {vld_q[0], accept};
            if (accept) begin
                mul_A <= in_a;
                mul_B <= in_b;
                cnt_q <= cnt_q + 1'b1;
            end
            if (start_ok) begin
                mode_q   <= cfg_mode;
                a_sign_q <= cfg_a_sign;
                b_sign_q <= cfg_b_sign;
                len_q    <= cfg_len;
                cnt_q    <= '0;
                acc_q    <= '0;
            end else if (vld_q[1]) begin
                acc_q <= acc_q + lane_sum;
            end
            if (finish) begin
                mode_q   <= '0;
                a_sign_q <= 1'b0;
                b_sign_q <= 1'b0;
            end
        end
    end

endmodule
